// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART types and frame constants
package spart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SAMP_MID = OVERSAMPLE_DEF / 2 - 1;
  localparam int SAMP_LAST = OVERSAMPLE_DEF - 1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/spart_sync2.sv
// spart_sync2: two-flop synchronizer for an async input, resets to 1
module spart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q <= 1'b1;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/spart_rx.sv
// spart_rx: oversampled 8N1 serial receiver with rda, framing and overrun status
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 rxd,
  input  logic                 read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  state_t state;
  logic [SW-1:0] samp_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic rxd_s;
  spart_sync2 u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxd_s));
  // read clears first so a same-clk good completion overrides it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      samp_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rda <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (read) begin
        rda <= 1'b0;
        overrun <= 1'b0;
      end
      if (rx_enable) begin
        case (state)
          IDLE: if (rxd_s == START_BIT) begin
            state <= START;
            samp_cnt <= '0;
          end
          START: begin
            samp_cnt <= samp_cnt + 1'b1;
            if (samp_cnt == MID) begin
              state <= rxd_s == START_BIT ? DATA : IDLE;
              samp_cnt <= '0;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            samp_cnt <= samp_cnt + 1'b1;
            if (samp_cnt == LAST) begin
              shift <= {rxd_s, shift[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) state <= STOP;
              else bit_cnt <= bit_cnt + 1'b1;
            end
          end
          STOP: begin
            samp_cnt <= samp_cnt + 1'b1;
            if (samp_cnt == LAST) begin
              state <= IDLE;
              if (rxd_s == STOP_BIT) begin
                rx_data <= shift;
                frame_err <= 1'b0;
                rda <= 1'b1;
                overrun <= rda && !read;
              end else frame_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: scoreboard bench for spart_rx driven at 16 ticks per bit
module tb_spart_rx;
  import spart_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic read = 1'b0;
  logic [1:0] en_cnt = 2'd0;
  logic rx_enable;
  logic [7:0] rx_data;
  logic rda, frame_err, overrun;
  logic [7:0] exp_q[$];
  logic [7:0] last_data;
  logic [7:0] exp_b;
  int errors = 0;
  int checks = 0;

  spart_rx dut (
    .clk(clk), .rst(rst), .rx_enable(rx_enable), .rxd(rxd), .read(read),
    .rx_data(rx_data), .rda(rda), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) en_cnt <= en_cnt + 2'd1;
  assign rx_enable = en_cnt == 2'd3;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic push);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    if (push && stop_v) exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (64) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic do_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset rx_data got %h exp 00", rx_data); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL reset rda got %b exp 0", rda); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun got %b exp 0", overrun); end
    rst = 1'b0;
    last_data = 8'h00;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'h22, 1'b1, 1'b1);
    exp_b = exp_q.pop_front();
    last_data = exp_b;
    checks++; if (rx_data !== exp_b) begin errors++; $display("FAIL basic rx_data got %h exp %h", rx_data, exp_b); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL basic rda got %b exp 1", rda); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic frame_err got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic overrun got %b exp 0", overrun); end
    do_read();
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL basic_read rda got %b exp 0", rda); end
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch state got %0d exp IDLE", dut.state); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL glitch rda got %b exp 0", rda); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch frame_err got %b exp 0", frame_err); end
  endtask

  task automatic test_frame_err();
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (64) @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr frame_err got %b exp 1", frame_err); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL ferr rda got %b exp 0", rda); end
    checks++; if (rx_data !== last_data) begin errors++; $display("FAIL ferr rx_data got %h exp %h", rx_data, last_data); end
    send_frame(8'h3C, 1'b1, 1'b1);
    exp_b = exp_q.pop_front();
    last_data = exp_b;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_recover frame_err got %b exp 0", frame_err); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL ferr_recover rda got %b exp 1", rda); end
    checks++; if (rx_data !== exp_b) begin errors++; $display("FAIL ferr_recover rx_data got %h exp %h", rx_data, exp_b); end
    do_read();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b1, 1'b1);
    exp_b = exp_q.pop_front();
    exp_b = exp_q.pop_front();
    last_data = exp_b;
    checks++; if (rx_data !== exp_b) begin errors++; $display("FAIL b2b rx_data got %h exp %h", rx_data, exp_b); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL b2b rda got %b exp 1", rda); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b overrun got %b exp 1", overrun); end
    do_read();
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL b2b_read rda got %b exp 0", rda); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_read overrun got %b exp 0", overrun); end
  endtask

  task automatic test_read_collision();
    bit hit;
    hit = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    exp_b = exp_q.pop_front();
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL coll_pre rda got %b exp 1", rda); end
    fork
      send_frame(8'h0F, 1'b1, 1'b1);
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk);
        if (dut.state == STOP && dut.samp_cnt == 4'hF && rx_enable) begin
          hit = 1'b1;
          read = 1'b1;
          @(negedge clk);
          read = 1'b0;
        end
      end
    join
    exp_b = exp_q.pop_front();
    last_data = exp_b;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL coll_timing completion got %b exp 1", hit); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL coll rda got %b exp 1", rda); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coll overrun got %b exp 0", overrun); end
    checks++; if (rx_data !== exp_b) begin errors++; $display("FAIL coll rx_data got %h exp %h", rx_data, exp_b); end
    do_read();
  endtask

  task automatic test_reset_mid();
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (64 * 5 + 32) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid rx_data got %h exp 00", rx_data); end
        checks++; if (rda !== 1'b0) begin errors++; $display("FAIL rstmid rda got %b exp 0", rda); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid frame_err got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid overrun got %b exp 0", overrun); end
        rst = 1'b0;
      end
    join
    repeat (64) @(negedge clk);
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL rstmid_partial rda got %b exp 0", rda); end
    send_frame(8'h81, 1'b1, 1'b1);
    exp_b = exp_q.pop_front();
    checks++; if (rx_data !== exp_b) begin errors++; $display("FAIL rstmid_next rx_data got %h exp %h", rx_data, exp_b); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL rstmid_next rda got %b exp 1", rda); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_next overrun got %b exp 0", overrun); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard leftover got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_read_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
